// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage: FSM states, RV32I load/store
// funct3 encodings, the CNN timeout writeback value and the misalignment rule.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StMemWait,
        StCnnWait
    } state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [31:0] CNN_TIMEOUT_VAL = 32'hFFFF_FFFF;

    // Halfword accesses need a[0]=0, word accesses need a[1:0]=0.
    function automatic logic is_misaligned(logic [2:0] funct3, logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (funct3)
            F3_LH, F3_LHU: bad = off[0];
            F3_LW:         bad = (off != 2'b00);
            default:       bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory request/response bus between the MEM stage (master) and memory (slave).
interface memory_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        ack;

    modport master (output req, we, addr, wdata, be, input rdata, ack);
    modport slave  (input req, we, addr, wdata, be, output rdata, ack);
endinterface

// File: rtl/load_store_align.sv
// Combinational lane logic: store byte-enables and replicated write data, and
// lane selection plus sign/zero extension of load data.
module load_store_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  st_funct3_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_wdata_o,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_val_o
);
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Size comes from funct3[1:0] so LBU/LHU requests get byte/half enables too.
    always_comb begin
        st_be_o    = 4'b1111;
        st_wdata_o = st_data_i;
        case (st_funct3_i[1:0])
            2'b00: begin
                st_be_o    = 4'b0001 << st_off_i;
                st_wdata_o = {4{st_data_i[7:0]}};
            end
            2'b01: begin
                st_be_o    = 4'b0011 << st_off_i;
                st_wdata_o = {2{st_data_i[15:0]}};
            end
            default: begin
                st_be_o    = 4'b1111;
                st_wdata_o = st_data_i;
            end
        endcase
    end

    always_comb begin
        ld_byte = ld_rdata_i[7:0];
        ld_half = ld_rdata_i[15:0];
        unique case (ld_off_i)
            2'd0: begin
                ld_byte = ld_rdata_i[7:0];
                ld_half = ld_rdata_i[15:0];
            end
            2'd1: begin
                ld_byte = ld_rdata_i[15:8];
                ld_half = ld_rdata_i[23:8];
            end
            2'd2: begin
                ld_byte = ld_rdata_i[23:16];
                ld_half = ld_rdata_i[31:16];
            end
            2'd3: begin
                ld_byte = ld_rdata_i[31:24];
                ld_half = {8'h00, ld_rdata_i[31:24]};
            end
            default: ;
        endcase
        case (ld_funct3_i)
            F3_LB:   ld_val_o = {{24{ld_byte[7]}}, ld_byte};
            F3_LH:   ld_val_o = {{16{ld_half[15]}}, ld_half};
            F3_LBU:  ld_val_o = {24'h0, ld_byte};
            F3_LHU:  ld_val_o = {16'h0, ld_half};
            default: ld_val_o = ld_rdata_i;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// Pipeline MEM stage: loads/stores over the dmem bus, waits on the CNN accelerator,
// drives MEM/WB. Optional MEM_MISALIGN_TRAP_EN adds misalign_err_o and blocks misaligned access.
module memory_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned CNN_TIMEOUT = 1024,
    parameter int unsigned PRED_W      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       ex_val_i,
    input  logic [31:0]       ex_rs2_i,
    input  logic [4:0]        ex_rd_i,
    input  logic              ex_valid_i,
    input  logic              ex_is_cnn_i,
    input  logic              ex_mem_rd_i,
    input  logic              ex_mem_wr_i,
    input  logic [2:0]        ex_funct3_i,
    memory_stage_if.master    dmem,
    input  logic              cnn_done_i,
    input  logic [PRED_W-1:0] cnn_pred_i,
    output logic              mem_stall_o,
    output logic [31:0]       mem_wb_val_o,
    output logic [4:0]        mem_wb_rd_o,
    output logic              mem_wb_valid_o,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic              misalign_err_o,
`endif
    output logic              cnn_timeout_o
);
    localparam int unsigned CntW = (CNN_TIMEOUT > 2) ? $clog2(CNN_TIMEOUT) : 1;

    state_e            state_q, state_d;
    logic              req_q, req_d, we_q, we_d;
    logic [31:0]       addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic [2:0]        ld_f3_q, ld_f3_d;
    logic [1:0]        ld_off_q, ld_off_d;
    logic [4:0]        rd_q, rd_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [31:0]       wb_val_q, wb_val_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic              wb_valid_q, wb_valid_d, timeout_q, timeout_d;
    logic              instr_present, is_mem, trap;
    logic [3:0]        st_be;
    logic [31:0]       st_wdata, ld_val;

    assign instr_present = ex_valid_i | ex_mem_wr_i;
    assign is_mem        = ex_mem_rd_i | ex_mem_wr_i;

`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;
    assign trap       = is_misaligned(ex_funct3_i, ex_val_i[1:0]);
    assign misalign_d = (state_q == StIdle) && instr_present && is_mem && trap;
    always_ff @(posedge clk) begin
        if (reset) misalign_q <= 1'b0;
        else       misalign_q <= misalign_d;
    end
    assign misalign_err_o = misalign_q;
`else
    assign trap = 1'b0;
`endif

    load_store_align u_align (
        .st_funct3_i (ex_funct3_i),
        .st_off_i    (ex_val_i[1:0]),
        .st_data_i   (ex_rs2_i),
        .st_be_o     (st_be),
        .st_wdata_o  (st_wdata),
        .ld_funct3_i (ld_f3_q),
        .ld_off_i    (ld_off_q),
        .ld_rdata_i  (dmem.rdata),
        .ld_val_o    (ld_val)
    );

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        ld_f3_d    = ld_f3_q;
        ld_off_d   = ld_off_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q;
        wb_val_d   = wb_val_q;
        wb_rd_d    = wb_rd_q;
        wb_valid_d = 1'b0;
        timeout_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (instr_present) begin
                    if (is_mem) begin
                        if (!trap) begin
                            state_d  = StMemWait;
                            req_d    = 1'b1;
                            we_d     = ex_mem_wr_i;
                            addr_d   = {ex_val_i[31:2], 2'b00};
                            be_d     = st_be;
                            wdata_d  = st_wdata;
                            ld_f3_d  = ex_funct3_i;
                            ld_off_d = ex_val_i[1:0];
                            rd_d     = ex_rd_i;
                        end
                    end else if (ex_is_cnn_i) begin
                        state_d = StCnnWait;
                        cnt_d   = '0;
                        rd_d    = ex_rd_i;
                    end else begin
                        wb_val_d   = ex_val_i;
                        wb_rd_d    = ex_rd_i;
                        wb_valid_d = ex_valid_i;
                    end
                end
            end
            StMemWait: begin
                if (dmem.ack) begin
                    state_d = StIdle;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    if (!we_q) begin
                        wb_val_d   = ld_val;
                        wb_rd_d    = rd_q;
                        wb_valid_d = 1'b1;
                    end
                end
            end
            StCnnWait: begin
                // Done takes priority over an expiry in the same cycle.
                if (cnn_done_i) begin
                    state_d    = StIdle;
                    wb_val_d   = 32'(cnn_pred_i);
                    wb_rd_d    = rd_q;
                    wb_valid_d = 1'b1;
                end else if (cnt_q == CntW'(CNN_TIMEOUT - 1)) begin
                    state_d    = StIdle;
                    wb_val_d   = CNN_TIMEOUT_VAL;
                    wb_rd_d    = rd_q;
                    wb_valid_d = 1'b1;
                    timeout_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            ld_f3_q    <= '0;
            ld_off_q   <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            wb_val_q   <= '0;
            wb_rd_q    <= '0;
            wb_valid_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            ld_f3_q    <= ld_f3_d;
            ld_off_q   <= ld_off_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            wb_val_q   <= wb_val_d;
            wb_rd_q    <= wb_rd_d;
            wb_valid_q <= wb_valid_d;
            timeout_q  <= timeout_d;
        end
    end

    assign mem_stall_o    = (state_q != StIdle) || (state_d != StIdle);
    assign dmem.req       = req_q;
    assign dmem.we        = we_q;
    assign dmem.addr      = addr_q;
    assign dmem.be        = be_q;
    assign dmem.wdata     = wdata_q;
    assign mem_wb_val_o   = wb_val_q;
    assign mem_wb_rd_o    = wb_rd_q;
    assign mem_wb_valid_o = wb_valid_q;
    assign cnn_timeout_o  = timeout_q;

endmodule
